frog_motion_ctrl: RTL
=====================

// Module: frog_motion_ctrl
// PURPOSE
// - Turns debounced direction switches into tile-stepped frog X/Y pixel positions, score and level-up pulses.
// - Sits between the Debounce_Filter outputs and the collision, sprite, obstacle and 7-segment stages.
// - Gated by the game-run flag; collision input sends the frog back to base and clears the score.
// PARAMETERS
// TILE_SIZE        16    pixels per tile (power of 2); every position output is a multiple of it
// H_VISIBLE_AREA   640   visible width in pixels; column count H_TILES = H_VISIBLE_AREA/TILE_SIZE
// V_VISIBLE_AREA   480   visible height in pixels; row count V_TILES = V_VISIBLE_AREA/TILE_SIZE
// X_BASE_TILE      19    frog spawn column
// Y_BASE_TILE      29    frog spawn row; must equal V_TILES-1 (bottom row)
// SCORE_INI        0     score after reset or collision
// SCORE_MAX        63    score saturates here
// COOLDOWN         4     cycles after a move before the next move is accepted
// HIT_HOLD         8     cycles the frog stays frozen at the collision spot
// REPEAT_CYCLES    1000  auto-repeat period (used only with FROG_AUTO_REPEAT_EN)
// PORTS
// i_Clk          in   1   system clock
// i_Rst_L        in   1   asynchronous active-low reset
// i_Game_Active  in   1   1 = game running
// i_Has_Collided in   1   level, 1 = frog overlaps a car this cycle
// i_Frog_Up      in   1   debounced switch, 1 = pressed
// i_Frog_Dn      in   1   debounced switch
// i_Frog_Lt      in   1   debounced switch
// i_Frog_Rt      in   1   debounced switch
// o_Frog_X       out  10  frog X in pixels = col*TILE_SIZE
// o_Frog_Y       out  10  frog Y in pixels = row*TILE_SIZE
// o_Score        out  6   crossings completed, saturating
// o_Level_Up     out  1   1-cycle pulse when row 0 is reached
// o_Hit          out  1   1-cycle pulse when a collision is accepted
// BEHAVIOUR
// - Reset (async, i_Rst_L=0): state IDLE; col=X_BASE_TILE, row=Y_BASE_TILE; o_Score=SCORE_INI.
//   o_Level_Up=0, o_Hit=0; switch-history registers=0. All outputs are registered.
// - Move request: rising edge of a switch (current=1, previous sample=0), i.e. one move per press.
// - Simultaneous edges: priority Up > Dn > Lt > Rt; lower-priority edges are dropped.
// - Latency: a move sampled at clock edge N appears on o_Frog_X/Y after edge N (1 cycle).
// - FSM states: IDLE, READY, COOL, HIT.
//   IDLE : frog held at base; moves ignored; i_Game_Active=1 -> READY.
//   READY: an accepted move updates col/row -> COOL (counter=COOLDOWN-1).
//          i_Has_Collided=1 -> HIT (counter=HIT_HOLD-1), o_Hit=1.
//   COOL : moves ignored while counter>0; counter=0 -> READY.
//          Collision -> HIT, as in READY.
//   HIT  : position frozen; counter=0 -> base position, o_Score=SCORE_INI, -> READY.
// - Any state with i_Game_Active=0 -> IDLE next cycle, frog to base; score kept.
// - Collision beats a move sampled in the same cycle; the move is discarded. Collision is ignored in IDLE and HIT.
// - Edges: Lt at col 0, Rt at col H_TILES-1 and Dn at row Y_BASE_TILE are ignored.
//   An ignored move stays in the current state and does not start COOL.
// - Scoring: Up from row 1 -> row 0 for exactly one cycle, o_Level_Up=1 that cycle.
//   o_Score=min(o_Score+1, SCORE_MAX). Next cycle: frog to base, state COOL.
// - Arithmetic: col/row are unsigned tile indices; X/Y = index << log2(TILE_SIZE), zero-extended to 10 bits.
// CONFIGURATION
// - FROG_AUTO_REPEAT_EN defined: a switch held through REPEAT_CYCLES consecutive cycles issues one more move request.
//   Held means the single highest-priority pressed switch. The repeat counter clears on release or a change of switch.
// - FROG_AUTO_REPEAT_EN undefined: edge-only moves; repeat counter and REPEAT_CYCLES logic are absent.
// TESTING (TILE_SIZE=16, H=64, V=64, X_BASE_TILE=1, Y_BASE_TILE=3, COOLDOWN=4, HIT_HOLD=8)
// 1. Release reset, Game_Active=1, one Up edge -> next cycle X=16, Y=32; a second Up 2 cycles later is ignored.
//    The same Up 4 cycles after the move is accepted -> Y=16.
// 2. From row 1, Up -> Y=0 for 1 cycle, Level_Up=1, Score 0->1; next cycle X=16, Y=48.
//    Score preloaded 63 stays 63.
// 3. At col 0, Lt -> X stays 0, no cooldown; at row 3, Dn ignored.
//    Up+Lt+Rt edges in one cycle -> only Y decrements.
// 4. Collision together with an Rt edge in READY -> X unchanged, Hit=1 for 1 cycle, position frozen 8 cycles.
//    Then X=16, Y=48, Score=0.
// 5. Drop Game_Active mid-COOL -> IDLE, base position, score kept; assert i_Rst_L=0 mid-HIT -> all reset values immediately.
// 6. FROG_AUTO_REPEAT_EN, REPEAT_CYCLES=5, hold Rt from col 0 -> X=16, then 32 five cycles later; undefined: X stays 16.

Source files
------------

// File: rtl/frog_motion_ctrl_if.sv
// Signal bundle between the debounced switch/game-control side and frog_motion_ctrl.
// The master drives the game and switch levels; the slave returns position, score and pulses.
interface frog_motion_ctrl_if;
  logic       i_Game_Active;
  logic       i_Has_Collided;
  logic       i_Frog_Up;
  logic       i_Frog_Dn;
  logic       i_Frog_Lt;
  logic       i_Frog_Rt;
  logic [9:0] o_Frog_X;
  logic [9:0] o_Frog_Y;
  logic [5:0] o_Score;
  logic       o_Level_Up;
  logic       o_Hit;

  modport master (
    output i_Game_Active, i_Has_Collided, i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt,
    input  o_Frog_X, o_Frog_Y, o_Score, o_Level_Up, o_Hit
  );

  modport slave (
    input  i_Game_Active, i_Has_Collided, i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt,
    output o_Frog_X, o_Frog_Y, o_Score, o_Level_Up, o_Hit
  );
endinterface

// File: rtl/frog_motion_ctrl.sv
// Tile-stepped frog movement, scoring and collision handling for the frogger game.
// Optional macro FROG_AUTO_REPEAT_EN: a held switch re-issues a move every REPEAT_CYCLES.
module frog_motion_ctrl #(
  parameter int TILE_SIZE      = 16,
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int X_BASE_TILE    = 19,
  parameter int Y_BASE_TILE    = 29,
  parameter int SCORE_INI      = 0,
  parameter int SCORE_MAX      = 63,
  parameter int COOLDOWN       = 4,
  parameter int HIT_HOLD       = 8,
  parameter int REPEAT_CYCLES  = 1000
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  frog_motion_ctrl_if.slave bus
);

  localparam int H_TILES    = H_VISIBLE_AREA / TILE_SIZE;
  localparam int V_TILES    = V_VISIBLE_AREA / TILE_SIZE;
  localparam int TILE_SHIFT = $clog2(TILE_SIZE);
  localparam int COL_W      = (H_TILES > 1) ? $clog2(H_TILES) : 1;
  localparam int ROW_W      = (V_TILES > 1) ? $clog2(V_TILES) : 1;
  localparam int CNT_MAX    = (COOLDOWN > HIT_HOLD) ? COOLDOWN : HIT_HOLD;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [COL_W-1:0] COL_BASE  = COL_W'(X_BASE_TILE);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(H_TILES - 1);
  localparam logic [ROW_W-1:0] ROW_BASE  = ROW_W'(Y_BASE_TILE);
  localparam logic [5:0]       SCORE_INI_V = 6'(SCORE_INI);
  localparam logic [5:0]       SCORE_MAX_V = 6'(SCORE_MAX);
  localparam logic [CNT_W-1:0] CNT_COOL  = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] CNT_HIT   = CNT_W'(HIT_HOLD - 1);

  // Elaboration-time sanity checks on the geometry and timing parameters.
  if (TILE_SIZE != (1 << TILE_SHIFT)) begin : g_bad_tile
    $error("TILE_SIZE must be a power of 2");
  end
  if (Y_BASE_TILE != V_TILES - 1) begin : g_bad_base_row
    $error("Y_BASE_TILE must be the bottom row");
  end
  if (COOLDOWN < 1 || HIT_HOLD < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
    $error("COOLDOWN, HIT_HOLD and REPEAT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, READY, COOL, HIT} state_t;
  typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DN, MV_LT, MV_RT} move_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [5:0]       score_q, score_d;
  logic             level_up_q, level_up_d;
  logic             hit_q, hit_d;
  logic [3:0]       sw, sw_prev_q, edges, req;
  move_t            move;
  logic             move_ok;
  logic [COL_W-1:0] move_col;
  logic [ROW_W-1:0] move_row;

  // Bit order gives the priority: Up (3) > Dn (2) > Lt (1) > Rt (0).
  assign sw    = {bus.i_Frog_Up, bus.i_Frog_Dn, bus.i_Frog_Lt, bus.i_Frog_Rt};
  assign edges = sw & ~sw_prev_q;

`ifdef FROG_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [3:0]       held, held_q;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_fire;

  always_comb begin
    held = 4'b0000;
    if      (sw[3]) held = 4'b1000;
    else if (sw[2]) held = 4'b0100;
    else if (sw[1]) held = 4'b0010;
    else if (sw[0]) held = 4'b0001;
  end

  // The count only runs while the same single switch stays the winner.
  always_comb begin
    rpt_fire  = 1'b0;
    rpt_cnt_d = '0;
    if (held != 4'b0000 && held == held_q) begin
      if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) rpt_fire = 1'b1;
      else                                         rpt_cnt_d = rpt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      held_q    <= 4'b0000;
      rpt_cnt_q <= '0;
    end else begin
      held_q    <= held;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign req = edges | (rpt_fire ? held : 4'b0000);
`else
  assign req = edges;
`endif

  // Pick the highest-priority request, then decide whether the board edge blocks it.
  always_comb begin
    move     = MV_NONE;
    move_ok  = 1'b0;
    move_col = col_q;
    move_row = row_q;
    if      (req[3]) move = MV_UP;
    else if (req[2]) move = MV_DN;
    else if (req[1]) move = MV_LT;
    else if (req[0]) move = MV_RT;
    case (move)
      MV_UP: if (row_q != '0)       begin move_ok = 1'b1; move_row = row_q - 1'b1; end
      MV_DN: if (row_q != ROW_BASE) begin move_ok = 1'b1; move_row = row_q + 1'b1; end
      MV_LT: if (col_q != '0)       begin move_ok = 1'b1; move_col = col_q - 1'b1; end
      MV_RT: if (col_q != COL_LAST) begin move_ok = 1'b1; move_col = col_q + 1'b1; end
      default: ;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    score_d    = score_q;
    level_up_d = 1'b0;
    hit_d      = 1'b0;

    if (!bus.i_Game_Active) begin
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = COL_BASE;
      row_d   = ROW_BASE;
    end else begin
      case (state_q)
        IDLE: begin
          col_d   = COL_BASE;
          row_d   = ROW_BASE;
          state_d = READY;
        end

        READY, COOL: begin
          if (bus.i_Has_Collided) begin
            state_d = HIT;
            cnt_d   = CNT_HIT;
            hit_d   = 1'b1;
          end else if (row_q == '0) begin
            // Goal row is shown for one cycle, then the frog respawns while cooling down.
            col_d   = COL_BASE;
            row_d   = ROW_BASE;
            state_d = COOL;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          end else if (state_q == COOL && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = READY;
            if (move_ok) begin
              col_d   = move_col;
              row_d   = move_row;
              state_d = COOL;
              cnt_d   = CNT_COOL;
              if (move_row == '0) begin
                level_up_d = 1'b1;
                score_d    = (score_q >= SCORE_MAX_V) ? SCORE_MAX_V : score_q + 1'b1;
              end
            end
          end
        end

        HIT: begin
          if (cnt_q == '0) begin
            col_d   = COL_BASE;
            row_d   = ROW_BASE;
            score_d = SCORE_INI_V;
            state_d = READY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      col_q      <= COL_BASE;
      row_q      <= ROW_BASE;
      score_q    <= SCORE_INI_V;
      level_up_q <= 1'b0;
      hit_q      <= 1'b0;
      sw_prev_q  <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      score_q    <= score_d;
      level_up_q <= level_up_d;
      hit_q      <= hit_d;
      sw_prev_q  <= sw;
    end
  end

  assign bus.o_Frog_X   = 10'(col_q) << TILE_SHIFT;
  assign bus.o_Frog_Y   = 10'(row_q) << TILE_SHIFT;
  assign bus.o_Score    = score_q;
  assign bus.o_Level_Up = level_up_q;
  assign bus.o_Hit      = hit_q;

endmodule
